// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler that shares a 4:1 WIDTH-bit mux among four requesters and
// caps each grant at MAX_HOLD transferred beats on a valid/ready output.
module mux4_rr_scheduler #(
    parameter int unsigned WIDTH    = 2,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [WIDTH-1:0] D3,
    input  logic             out_ready,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] Y,
    output logic             out_valid,
    output logic             busy
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

    logic [0:0]       state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] dsel;
    logic             xfer;
    logic             rel;

    // First set bit of r, searching circularly upward starting at base.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = base + 2'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        unique case (sel_q)
            2'd0: dsel = D0;
            2'd1: dsel = D1;
            2'd2: dsel = D2;
            2'd3: dsel = D3;
        endcase
    end

    assign busy      = (state_q == StGrant);
    assign out_valid = busy & req[sel_q];
    // Gate the data so X on an unselected or idle source never reaches Y.
    assign Y         = out_valid ? dsel : '0;
    assign gnt       = gnt_q;
    assign sel       = sel_q;

    assign xfer = out_valid & out_ready;
    assign rel  = busy & (~req[sel_q] | (xfer & (cnt_q == HoldLast)));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    sel_d   = rr_pick(req, last_q + 2'd1);
                    gnt_d   = 4'b0001 << sel_d;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (rel) begin
                    last_d = sel_q;
                    cnt_d  = '0;
                    // Current source is searched last, so a lone requester regrants bubble-free.
                    if (|req) begin
                        sel_d = rr_pick(req, sel_q + 2'd1);
                        gnt_d = 4'b0001 << sel_d;
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: per-cycle vector table plus hand-written corner
// sequences, with expected outputs queued on drive and popped when sampled.
module tb_mux4_rr_scheduler;

    localparam int unsigned WIDTH    = 2;
    localparam int unsigned MAX_HOLD = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] D0, D1, D2, D3;
    logic             out_ready;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] Y;
    logic             out_valid;
    logic             busy;

    mux4_rr_scheduler #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .Y         (Y),
        .out_valid (out_valid),
        .busy      (busy)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic       dx;
        logic       chk;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             valid;
        logic             busy;
        logic [WIDTH-1:0] y;
    } exp_t;

    logic [WIDTH-1:0] dval [4];
    vec_t             vecs [$];
    exp_t             exp_q [$];
    int               n_checks;
    int               n_fail;
    int               row;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic rdy,
                                input logic dx, input logic chk, input logic [3:0] g,
                                input logic [1:0] s, input logic v, input logic b);
        vec_t t;
        t.rst = r;  t.req = rq;  t.rdy = rdy;  t.dx = dx;  t.chk = chk;
        t.gnt = g;  t.sel = s;   t.valid = v;  t.busy = b;
        return t;
    endfunction

    // First row's outputs predate the reset edge and are not checked.
    function automatic void add_reset(input logic [3:0] rq);
        vecs.push_back(mk(1'b1, rq, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, rq, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, rq, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s row %0d: got %b, expected %b", name, row, act, want);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard row %0d: got empty queue, expected an entry", row);
        end else begin
            e = exp_q.pop_front();
            cmp("gnt", {4'b0, gnt}, {4'b0, e.gnt});
            cmp("sel", {6'b0, sel}, {6'b0, e.sel});
            cmp("out_valid", {7'b0, out_valid}, {7'b0, e.valid});
            cmp("busy", {7'b0, busy}, {7'b0, e.busy});
            cmp("Y", {6'b0, Y}, {6'b0, e.y});
        end
    endtask

    task automatic drive(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst       = v.rst;
        req       = v.req;
        out_ready = v.rdy;
        if (v.dx) begin
            D0 = 'x; D1 = 'x; D2 = 'x; D3 = 'x;
        end else begin
            D0 = dval[0]; D1 = dval[1]; D2 = dval[2]; D3 = dval[3];
        end
        if (v.chk) begin
            e.gnt   = v.gnt;
            e.sel   = v.sel;
            e.valid = v.valid;
            e.busy  = v.busy;
            e.y     = v.valid ? dval[v.sel] : '0;
            exp_q.push_back(e);
            #1;
            check_out();
        end
        row++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dval[0] = 2'b00; dval[1] = 2'b10; dval[2] = 2'b01; dval[3] = 2'b11;
        n_checks = 0;
        n_fail   = 0;
        row      = 0;

        // Reset, then full rotation 0,1,2,3,0 with MAX_HOLD beats each.
        add_reset(4'b1111);
        for (int s = 0; s < 5; s++)
            for (int b = 0; b < ((s == 4) ? 2 : 4); b++)
                vecs.push_back(mk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1,
                                  4'b0001 << (s % 4), 2'(s % 4), 1'b1, 1'b1));
        // Lone requester 2 is regranted across the hold limit with no bubble.
        add_reset(4'b0100);
        for (int b = 0; b < 10; b++)
            vecs.push_back(mk(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1));
        // Source 1 stalled 6 cycles, then exactly MAX_HOLD transfers, then source 0.
        add_reset(4'b0010);
        for (int b = 0; b < 6; b++)
            vecs.push_back(mk(1'b0, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1));
        for (int b = 0; b < 4; b++)
            vecs.push_back(mk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1));

        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        D0 = dval[0]; D1 = dval[1]; D2 = dval[2]; D3 = dval[3];
        repeat (2) @(posedge clk);

        foreach (vecs[i]) drive(vecs[i]);

        // Source 3 drops its request after 2 beats while source 0 waits.
        drive(mk(1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1));
        drive(mk(1'b0, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1));
        drive(mk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b0, 1'b1));
        drive(mk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1));

        // Reset mid-burst on source 2; the count must restart so 4 beats precede release.
        drive(mk(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        drive(mk(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1));
        drive(mk(1'b0, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1));
        drive(mk(1'b1, 4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1));
        drive(mk(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int b = 0; b < 4; b++)
            drive(mk(1'b0, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1));
        drive(mk(1'b0, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_rr_scheduler.md
Name: mux4_rr_scheduler

Overview:
- Round-robin scheduler that shares a 4:1, WIDTH-bit multiplexer datapath among four requesters.
- Drives the mux select from registered grant state and presents the selected data to a downstream consumer with a valid/ready handshake.
- Limits each grant to MAX_HOLD transferred beats so no requester can monopolise the output.
- Sits directly in front of the combinational 4:1 mux stage in the combination-circuit datapath.

Parameters:
- WIDTH, 2, data width of each input and of Y.
- MAX_HOLD, 4, maximum beats transferred per grant; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per source; req[i] high means source i has data on Di.
- D0  input  WIDTH  source 0 data.
- D1  input  WIDTH  source 1 data.
- D2  input  WIDTH  source 2 data.
- D3  input  WIDTH  source 3 data.
- out_ready  input  1  downstream accepts Y this cycle.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- sel  output  2  registered mux select (index of the granted source).
- Y  output  WIDTH  D[sel] when out_valid, else 0 (combinational).
- out_valid  output  1  (state==GRANT) & req[sel] (combinational).
- busy  output  1  high in GRANT state.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. rst has priority over all other inputs at the edge where it is sampled.
- Reset values: state=IDLE, gnt=0000, sel=00, last=3, beat count=0, busy=0, out_valid=0, Y=0.
- Reset mid-grant: the next edge forces the reset values. No beat is counted on that edge.
- States: IDLE and GRANT.
- IDLE:
  - If req!=0 at an edge, pick the first set bit searching circularly from last+1.
  - Load sel and gnt, clear count, go to GRANT.
  - Latency: a request sampled at edge k gives gnt/out_valid in the cycle after edge k.
  - If req==0, stay in IDLE.
- GRANT:
  - Transfer: out_valid & out_ready at an edge. Count increments by 1.
  - out_ready low: no transfer, count holds, grant holds with no timeout.
  - req[sel] low: out_valid drops in the same cycle (combinational) and Y=0.
- Release condition, evaluated at each edge in GRANT:
  - req[sel]==0, or
  - a transfer with count==MAX_HOLD-1.
  - Both true at the same edge: a single release, identical result.
- On release:
  - last<=sel and count<=0.
  - If any req bit is set, regrant in the same edge to the first set bit searching circularly from sel+1. The current source is searched last, so a lone requester that hit MAX_HOLD is regranted with no bubble.
  - Otherwise go to IDLE with gnt=0000.
- Counter width is 4 bits; it never exceeds MAX_HOLD-1.
- gnt is always one-hot or zero, and gnt[sel]==1 whenever busy=1.
- Requesters changing req while not granted have no effect until the next arbitration edge.
- Y and out_valid must never be X after reset, even with D inputs X while out_valid=0.

Test Plan:
1. rst=1 for 2 cycles with req=1111 -> gnt=0000, sel=00, busy=0, Y=00 throughout. After release, the first grant goes to source 0 (last=3).
2. D0=00, D1=10, D2=01, D3=11, req=1111, out_ready=1, MAX_HOLD=4 -> grant order 0,1,2,3,0 with 4 beats each and no idle gaps. Y shows 00x4, 10x4, 01x4, 11x4.
3. Only req[2]=1 continuously, out_ready=1 -> sel stays 10. out_valid is continuous across the MAX_HOLD boundary (regrant, no bubble). Y=01 every cycle.
4. Source 1 granted, out_ready=0 for 6 cycles, then 1 -> out_valid=1 and Y=10 held 6 cycles with count 0. Then exactly 4 transfers before release.
5. Source 3 granted, req[3] drops after 2 beats while req[0]=1 -> out_valid=0 and Y=00 in the drop cycle. At the next edge gnt=0001, sel=00, busy stays 1.
6. rst asserted mid-burst on source 2 at beat 2 -> next cycle all outputs are at reset values. With req=0100 held, the regrant to source 2 appears one cycle after rst deasserts, with count restarting at 0.
